// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, result flag bit
// positions and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_INV  = 3'd7;

  // Bit positions inside res_flags = {borrow,carry,equal,less,more}
  localparam int FLG_BORROW = 4;
  localparam int FLG_CARRY  = 3;
  localparam int FLG_EQUAL  = 2;
  localparam int FLG_LESS   = 1;
  localparam int FLG_MORE   = 0;

  // Settle counter width; covers the legal SETTLE_CYCLES range 1..15
  localparam int SETTLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, result and ALU-side signals of the issue sequencer.
// slave: the sequencer's view; master: the surrounding environment's view.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_control;
  logic [7:0] alu_c;
  logic       alu_borrow;
  logic       alu_carry;
  logic       alu_equal;
  logic       alu_less;
  logic       alu_more;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_c;
  logic [4:0] res_flags;
  logic       res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_control,
    input  alu_c, alu_borrow, alu_carry, alu_equal, alu_less, alu_more,
    output res_valid, res_c, res_flags, res_err,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_control,
    output alu_c, alu_borrow, alu_carry, alu_equal, alu_less, alu_more,
    input  res_valid, res_c, res_flags, res_err,
    output res_ready
  );
endinterface

// File: rtl/alu_issue_ctrl_flag_mask.sv
// Combinational capture logic: selects which ALU flags are meaningful for the
// issued opcode and repairs the compare flags, which the ALU never clears.
module alu_flag_mask
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] c,
  input  logic       borrow,
  input  logic       carry,
  input  logic       equal,
  input  logic       less,
  input  logic       more,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] res_c,
  output logic [4:0] res_flags,
  output logic       res_err
);

  logic [2:0] cmp_raw;

  assign cmp_raw = {equal, less, more};

  // Mask flags per opcode; a CMP with stale extra bits is recomputed from a/b
  always_comb begin
    res_c     = c;
    res_flags = '0;
    res_err   = 1'b0;
    case (op)
      OP_ADD: res_flags[FLG_CARRY]  = carry;
      OP_SUB: res_flags[FLG_BORROW] = borrow;
      OP_CMP: begin
        res_c = '0;
        if ($onehot(cmp_raw)) begin
          res_flags[2:0] = cmp_raw;
        end else begin
          res_flags[FLG_MORE]  = (a > b);
          res_flags[FLG_LESS]  = (a < b);
          res_flags[FLG_EQUAL] = (a == b);
        end
      end
      OP_INV: begin
        res_c   = '0;
        res_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 8-bit combinational ALU: registers one
// command onto the ALU inputs, waits SETTLE_CYCLES, captures a masked result
// and holds it on a valid/ready port until consumed.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  io,
  output logic [CNT_W-1:0] op_count
);

  state_t              state_q, state_d;
  logic                accept, capture, consume;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [7:0]          alu_a_q, alu_b_q;
  logic [2:0]          alu_ctl_q;
  logic [7:0]          res_c_q, mask_c;
  logic [4:0]          res_flags_q, mask_flags;
  logic                res_err_q, mask_err;
  logic [CNT_W-1:0]    op_count_q;

  // cmd_ready is held low while reset is asserted so every handshake output reads 0
  assign io.cmd_ready   = (state_q == IDLE) && !rst;
  assign io.res_valid   = (state_q == DONE);
  assign io.alu_a       = alu_a_q;
  assign io.alu_b       = alu_b_q;
  assign io.alu_control = alu_ctl_q;
  assign io.res_c       = res_c_q;
  assign io.res_flags   = res_flags_q;
  assign io.res_err     = res_err_q;
  assign op_count       = op_count_q;

  alu_flag_mask u_mask (
    .op        (alu_ctl_q),
    .c         (io.alu_c),
    .borrow    (io.alu_borrow),
    .carry     (io.alu_carry),
    .equal     (io.alu_equal),
    .less      (io.alu_less),
    .more      (io.alu_more),
    .a         (alu_a_q),
    .b         (alu_b_q),
    .res_c     (mask_c),
    .res_flags (mask_flags),
    .res_err   (mask_err)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: if (io.cmd_valid) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (settle_cnt == SETTLE_W'(1)) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (io.res_ready) begin
        consume = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operand/opcode registers; they hold between operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= OP_INV;
    end else if (accept) begin
      alu_a_q   <= io.cmd_a;
      alu_b_q   <= io.cmd_b;
      alu_ctl_q <= io.cmd_op;
    end
  end

  // Settle counter: loaded on accept, counts down while in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           settle_cnt <= '0;
    else if (accept)                                   settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
    else if (state_q == EXEC && settle_cnt != '0)      settle_cnt <= settle_cnt - SETTLE_W'(1);
  end

  // Result register, written only on capture so it is stable through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_c_q     <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
    end else if (capture) begin
      res_c_q     <= mask_c;
      res_flags_q <= mask_flags;
      res_err_q   <= mask_err;
    end
  end

  // Consumed-result counter, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               op_count_q <= '0;
    else if (consume && op_count_q != '1)  op_count_q <= op_count_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural sticky-flag ALU model attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] op_count;
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  logic [7:0]  gc;
  logic [4:0]  gf;
  logic        ge;

  always #5 clk = ~clk;

  alu_issue_ctrl_if io();

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (io.slave),
    .op_count (op_count)
  );

  // ALU model: carry/borrow refresh on ADD/SUB, compare flags only ever get
  // set, and opcode 7 clears everything.
  logic [7:0] m_c = 8'h00;
  logic m_borrow = 1'b0, m_carry = 1'b0, m_eq = 1'b0, m_lt = 1'b0, m_gt = 1'b0;
  logic [8:0] m_sum;

  always @(io.alu_a or io.alu_b or io.alu_control) begin
    case (io.alu_control)
      3'd0: begin m_sum = {1'b0, io.alu_a} + {1'b0, io.alu_b}; m_c = m_sum[7:0]; m_carry = m_sum[8]; end
      3'd1: begin m_c = io.alu_a - io.alu_b; m_borrow = (io.alu_a < io.alu_b); end
      3'd2: m_c = io.alu_a ^ io.alu_b;
      3'd3: m_c = io.alu_a & io.alu_b;
      3'd4: m_c = ~(io.alu_a | io.alu_b);
      3'd5: m_c = ~(io.alu_a & io.alu_b);
      3'd6: begin
        m_c = io.alu_a - io.alu_b;
        if (io.alu_a == io.alu_b) m_eq = 1'b1;
        if (io.alu_a <  io.alu_b) m_lt = 1'b1;
        if (io.alu_a >  io.alu_b) m_gt = 1'b1;
      end
      default: begin m_c = 8'h00; m_borrow = 0; m_carry = 0; m_eq = 0; m_lt = 0; m_gt = 0; end
    endcase
  end

  assign io.alu_c      = m_c;
  assign io.alu_borrow = m_borrow;
  assign io.alu_carry  = m_carry;
  assign io.alu_equal  = m_eq;
  assign io.alu_less   = m_lt;
  assign io.alu_more   = m_gt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result from plain integer arithmetic on the operands
  function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] c, output logic [4:0] f, output logic e);
    int ai, bi;
    ai = a; bi = b; c = 8'h00; f = 5'b0; e = 1'b0;
    case (op)
      3'd0: begin c = 8'((ai + bi) % 256); if (ai + bi > 255) f = 5'b01000; end
      3'd1: begin c = 8'((ai - bi + 256) % 256); if (ai < bi) f = 5'b10000; end
      3'd2: c = a ^ b;
      3'd3: c = a & b;
      3'd4: c = ~(a | b);
      3'd5: c = ~(a & b);
      3'd6: f = (ai > bi) ? 5'b00001 : (ai < bi) ? 5'b00010 : 5'b00100;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit pulse,
                       output logic [7:0] oc, output logic [4:0] of, output logic oe);
    logic [7:0] ec;
    logic [4:0] ef;
    logic       ee;
    int         n;
    ref_op(op, a, b, ec, ef, ee);
    @(negedge clk);
    chk("cmd_ready_idle", io.cmd_ready, 1);
    io.cmd_valid = 1'b1; io.cmd_op = op; io.cmd_a = a; io.cmd_b = b;
    io.res_ready = (hold == 0);
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    chk("alu_a_reg", io.alu_a, a);
    chk("alu_b_reg", io.alu_b, b);
    chk("alu_ctl_reg", io.alu_control, op);
    n = 1;
    while (!io.res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, SETTLE + 1);
    oc = io.res_c; of = io.res_flags; oe = io.res_err;
    chk("res_c", io.res_c, ec);
    chk("res_flags", io.res_flags, ef);
    chk("res_err", io.res_err, ee);
    chk("cmd_ready_done", io.cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == hold / 2) begin
        @(negedge clk);
        io.cmd_valid = 1'b1; io.cmd_op = 3'd0; io.cmd_a = ~a; io.cmd_b = 8'hFF;
        @(posedge clk); #1;
        io.cmd_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      chk("bp_valid", io.res_valid, 1);
      chk("bp_res_c", io.res_c, ec);
      chk("bp_flags", io.res_flags, ef);
      chk("bp_cmd_ready", io.cmd_ready, 0);
      chk("bp_alu_a", io.alu_a, a);
    end
    if (hold > 0) begin
      @(negedge clk);
      io.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    if (exp_count < 65535) exp_count++;
    chk("valid_after_hs", io.res_valid, 0);
    chk("op_count", op_count, exp_count);
    chk("cmd_ready_after_hs", io.cmd_ready, 1);
    chk("alu_a_hold", io.alu_a, a);
  endtask

  initial begin
    io.cmd_valid = 1'b0; io.cmd_op = 3'd0; io.cmd_a = 8'h00; io.cmd_b = 8'h00;
    io.res_ready = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_res_valid", io.res_valid, 0);
    chk("rst_cmd_ready", io.cmd_ready, 0);
    chk("rst_alu_ctl", io.alu_control, 3'd7);
    chk("rst_alu_a", io.alu_a, 0);
    chk("rst_res_c", io.res_c, 0);
    chk("rst_flags", io.res_flags, 0);
    chk("rst_err", io.res_err, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("cmd_ready_after_rst", io.cmd_ready, 1);

    // res_ready with nothing valid has no effect
    io.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_ready_no_count", op_count, 0);
    chk("idle_ready_no_valid", io.res_valid, 0);

    do_op(3'd0, 8'd200, 8'd100, 0, 1'b0, gc, gf, ge);
    chk("add_c", gc, 8'h2C); chk("add_flags", gf, 5'b01000);
    chk("add_count", op_count, 1);
    do_op(3'd1, 8'd5, 8'd9, 0, 1'b0, gc, gf, ge);
    chk("sub_c", gc, 8'hFC); chk("sub_flags", gf, 5'b10000);
    do_op(3'd6, 8'd9, 8'd1, 0, 1'b0, gc, gf, ge);
    chk("cmp_more", gf, 5'b00001);
    do_op(3'd6, 8'd3, 8'd7, 0, 1'b0, gc, gf, ge);
    chk("cmp_less_stale", gf, 5'b00010);
    do_op(3'd6, 8'h10, 8'h10, 0, 1'b0, gc, gf, ge);
    chk("cmp_eq_c", gc, 0); chk("cmp_eq_stale", gf, 5'b00100);
    do_op(3'd7, 8'h55, 8'hAA, 0, 1'b0, gc, gf, ge);
    chk("inv_err", ge, 1); chk("inv_c", gc, 0); chk("inv_flags", gf, 0);
    do_op(3'd0, 8'd1, 8'd1, 0, 1'b0, gc, gf, ge);
    chk("add11_err", ge, 0); chk("add11_c", gc, 8'd2);

    // backpressure for 10 cycles with a stray command pulse
    do_op(3'd2, 8'hA5, 8'h3C, 10, 1'b1, gc, gf, ge);
    chk("bp_xor_c", gc, 8'h99);

    // reset while the op is in EXEC
    @(negedge clk);
    io.cmd_valid = 1'b1; io.cmd_op = 3'd0; io.cmd_a = 8'd7; io.cmd_b = 8'd8;
    io.res_ready = 1'b1;
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", io.res_valid, 0);
    chk("midrst_alu_ctl", io.alu_control, 3'd7);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_res_c", io.res_c, 0);
    @(negedge clk); rst = 1'b0;
    exp_count = 0;
    #1 chk("midrst_cmd_ready", io.cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_output", io.res_valid, 0);

    // randomized operations against the reference
    for (int k = 0; k < 150; k++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), gc, gf, ge);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
